// File: rtl/sram64x7_pkg.sv
// Shared definitions for the fakeram45_64x7 controller: default widths, FSM states, request record.
// The optional start-up clear is enabled with SRAM64X7_INIT_CLEAR_EN.
package sram64x7_pkg;

    localparam int SRAM_ADDR_W = 6;
    localparam int SRAM_DATA_W = 7;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_DATA_W-1:0] wmask;
    } sram_req_t;

endpackage

// File: rtl/sram64x7_rsp_buf.sv
// First-word-fall-through response FIFO with occupancy output; an incoming word is
// presented straight through when the FIFO is empty, so read data is visible on arrival.
module sram64x7_rsp_buf #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            pushData_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] entries_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic              empty;
    logic              doWrite;
    logic              doRead;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A push that is consumed in the same cycle while empty never lands in storage.
    assign empty   = (count_q == '0);
    assign doWrite = push_i && !(empty && pop_i);
    assign doRead  = pop_i && !empty;

    assign valid_o = !empty || push_i;
    assign data_o  = empty ? pushData_i : entries_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWrite) wrPtr_q <= nextPtr(wrPtr_q);
            if (doRead)  rdPtr_q <= nextPtr(rdPtr_q);
            count_q <= count_q + CNT_W'(doWrite) - CNT_W'(doRead);
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) entries_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/sram64x7_ctrl.sv
// Initiator-side controller for fakeram45_64x7: request port -> macro drive, read data -> response FIFO.
// Define SRAM64X7_INIT_CLEAR_EN to zero the whole macro after every reset before accepting requests.
module sram64x7_ctrl
    import sram64x7_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef SRAM64X7_INIT_CLEAR_EN
    localparam state_e RESET_STATE = ST_INIT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    logic [ADDR_W-1:0] initAddr_q;
`else
    localparam state_e RESET_STATE = ST_RUN;
`endif

    state_e            state_q;
    logic              inFlight_q;
    logic              inFlight_d;
    logic              accept;
    logic              hasCredit;
    logic [CNT_W:0]    used;
    logic [CNT_W-1:0]  bufCount;
    logic              bufValid;
    logic [DATA_W-1:0] bufData;
    logic              push;
    logic              pop;
    sram_req_t         memReq;
    logic              memCe;

    // Credits come only from registered state, so a pop frees a slot one cycle later.
    assign used      = {1'b0, bufCount} + (CNT_W+1)'(inFlight_q);
    assign hasCredit = used < (CNT_W+1)'(RSP_DEPTH);
    assign req_ready = !rst && (state_q == ST_RUN) && hasCredit;
    assign accept    = req_valid && req_ready;
    assign inFlight_d = accept && !req_we;

    always_comb begin
        memReq = '0;
        memCe  = 1'b0;
        if (accept) begin
            memCe        = 1'b1;
            memReq.we    = req_we;
            memReq.addr  = req_addr;
            memReq.wdata = req_wdata;
            memReq.wmask = req_we ? req_wmask : '0;
        end
`ifdef SRAM64X7_INIT_CLEAR_EN
        if (!rst && state_q == ST_INIT) begin
            memCe        = 1'b1;
            memReq.we    = 1'b1;
            memReq.addr  = initAddr_q;
            memReq.wdata = '0;
            memReq.wmask = '1;
        end
`endif
    end

    assign mem_ce    = memCe;
    assign mem_we    = memReq.we;
    assign mem_addr  = memReq.addr;
    assign mem_wd    = memReq.wdata;
    assign mem_wmask = memReq.wmask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            inFlight_q <= 1'b0;
`ifdef SRAM64X7_INIT_CLEAR_EN
            initAddr_q <= '0;
`endif
        end else begin
            inFlight_q <= inFlight_d;
`ifdef SRAM64X7_INIT_CLEAR_EN
            if (state_q == ST_INIT) begin
                if (initAddr_q == LAST_ADDR) state_q <= ST_RUN;
                initAddr_q <= initAddr_q + 1'b1;
            end
`endif
        end
    end

    // Macro read latency is one cycle: the word on mem_rd belongs to last cycle's read.
    assign push = inFlight_q && !rst;
    assign pop  = rsp_valid && rsp_ready;

    sram64x7_rsp_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rspBuf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pushData_i (mem_rd),
        .pop_i      (pop),
        .valid_o    (bufValid),
        .data_o     (bufData),
        .count_o    (bufCount)
    );

    assign rsp_valid = !rst && bufValid;
    assign rsp_rdata = rst ? '0 : bufData;

endmodule

// File: tb/tb_sram64x7_ctrl.sv
// Directed self-checking bench for sram64x7_ctrl with a behavioural fakeram45_64x7 model.
// Build with SRAM64X7_INIT_CLEAR_EN defined to also exercise the start-up clear.
module tb_sram64x7_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [5:0] req_addr;
    logic [6:0] req_wdata;
    logic [6:0] req_wmask;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [6:0] rsp_rdata;
    logic       mem_ce;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [6:0] mem_wd;
    logic [6:0] mem_wmask;
    logic [6:0] mem_rd = 7'h00;

    logic [6:0] macroMem [64] = '{default: 7'h2A};
    logic [6:0] expData  [64];

    int checkCount = 0;
    int errCount   = 0;

    sram64x7_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_wmask (mem_wmask),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural macro: masked write, or registered read with one cycle of latency.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we)
                macroMem[mem_addr] <= (macroMem[mem_addr] & ~mem_wmask) | (mem_wd & mem_wmask);
            else
                mem_rd <= macroMem[mem_addr];
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [5:0] a,
                                 input logic [6:0] d, input logic [6:0] m);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic writeWord(input logic [5:0] a, input logic [6:0] d, input logic [6:0] m);
        applyStimulus(1'b1, 1'b1, a, d, m);
        #1;
        waitReady("wr");
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        #1;
    endtask

    task automatic readCheck(input logic [5:0] a, input logic [6:0] expected, input string tag);
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, a, '0, '0);
        #1;
        waitReady(tag);
        checkOutput({tag, "_ce"}, 32'(mem_ce), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        #1;
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(rsp_rdata), 32'(expected));
        tick();
    endtask

    task automatic applyReset(input string tag);
        int bad = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_ce"}, 32'(mem_ce), 32'd0);
        rst = 1'b0;
        #1;
`ifdef SRAM64X7_INIT_CLEAR_EN
        for (int i = 0; i < 64; i++) begin
            if (req_ready || rsp_valid || !mem_ce) bad++;
            tick();
        end
        checkOutput({tag, "_init_busy"}, 32'(bad), 32'd0);
`endif
        checkOutput({tag, "_run_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        applyReset("reset");

        // Full write then read back.
        writeWord(6'd5, 7'h55, 7'h7F);
        readCheck(6'd5, 7'h55, "rd5");

        // Partial mask keeps the upper bits of the old word.
        writeWord(6'd3, 7'h7F, 7'h7F);
        writeWord(6'd3, 7'h00, 7'h0F);
        readCheck(6'd3, 7'h70, "mask3");

        // Write followed immediately by a read of the same word.
        applyStimulus(1'b1, 1'b1, 6'd9, 7'h11, 7'h7F);
        #1;
        waitReady("wrrd");
        tick();
        applyStimulus(1'b1, 1'b0, 6'd9, '0, '0);
        #1;
        checkOutput("wrrd_ready", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("wrrd_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wrrd_data", 32'(rsp_rdata), 32'h11);
        tick();

        // Backpressure: only RSP_DEPTH reads outstanding, order kept, no ready bypass.
        writeWord(6'd10, 7'h0A, 7'h7F);
        writeWord(6'd11, 7'h0B, 7'h7F);
        writeWord(6'd12, 7'h0C, 7'h7F);
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'd10, '0, '0);
        #1;
        checkOutput("bp_acc0", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 6'd11, '0, '0);
        #1;
        checkOutput("bp_acc1", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 6'd12, '0, '0);
        #1;
        checkOutput("bp_full", 32'(req_ready), 32'd0);
        checkOutput("bp_head_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_head", 32'(rsp_rdata), 32'h0A);
        tick();
        checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
        checkOutput("bp_hold_data", 32'(rsp_rdata), 32'h0A);
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_no_bypass", 32'(req_ready), 32'd0);
        tick();
        checkOutput("bp_ready_back", 32'(req_ready), 32'd1);
        checkOutput("bp_second", 32'(rsp_rdata), 32'h0B);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("bp_third_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_third", 32'(rsp_rdata), 32'h0C);
        tick();
        checkOutput("bp_drained", 32'(rsp_valid), 32'd0);

        // Streaming reads over the whole array: one response every cycle.
        for (int i = 0; i < 64; i++) begin
            expData[i] = 7'((i * 5 + 3) & 8'h7F);
            writeWord(6'(i), expData[i], 7'h7F);
        end
        rsp_ready = 1'b1;
        bad = 0;
        for (int i = 0; i <= 64; i++) begin
            if (i < 64) applyStimulus(1'b1, 1'b0, 6'(i), '0, '0);
            else        applyStimulus(1'b0, 1'b0, '0, '0, '0);
            #1;
            if (i > 0) begin
                if (!rsp_valid) bad++;
                checkOutput($sformatf("stream_data%0d", i - 1), 32'(rsp_rdata), 32'(expData[i-1]));
            end
            if (i < 64 && !req_ready) bad++;
            tick();
        end
        checkOutput("stream_bubbles", 32'(bad), 32'd0);
        checkOutput("stream_idle", 32'(rsp_valid), 32'd0);

        // Reset with one read in flight and one buffered: nothing stale may appear.
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'd1, '0, '0);
        #1;
        checkOutput("rstf_acc0", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 6'd2, '0, '0);
        #1;
        checkOutput("rstf_acc1", 32'(req_ready), 32'd1);
        tick();
        checkOutput("rstf_pending", 32'(rsp_valid), 32'd1);
        applyReset("rstf");
        rsp_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) bad++;
            tick();
        end
        checkOutput("rstf_no_stale", 32'(bad), 32'd0);

`ifdef SRAM64X7_INIT_CLEAR_EN
        readCheck(6'd20, 7'h00, "clr20");
        readCheck(6'd63, 7'h00, "clr63");
`else
        readCheck(6'd20, expData[20], "keep20");
        readCheck(6'd63, expData[63], "keep63");
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
